// File: rtl/ifetch_queue.sv
// Instruction fetch unit: req/ack fetch engine feeding a PC-tagged prefetch queue.
// Optional same-cycle bypass of an arriving word into an empty queue: define IFQ_BYPASS_EN.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [31:0]     fpc_r, fpc_next_s;
  logic [31:0]     hold_r, hold_next_s;
  logic [31:0]     addr_r;
  logic            req_r;
  logic            valid_r;
  logic [CW-1:0]   count_r, count_next_s;
  logic [PW-1:0]   rd_r, wr_r, rd_next_s, wr_next_s;
  logic [31:0]     inst_mem_r [DEPTH];
  logic [31:0]     pc_mem_r   [DEPTH];
  logic [31:0]     rpc_s;
  logic            ack_ok_s, enq_s, deq_s, byp_s;

  assign rpc_s    = redirect_pc & 32'hFFFF_FFFC;
  assign ack_ok_s = (state_r == WAIT) && imem_ack && !redirect;

`ifdef IFQ_BYPASS_EN
  assign byp_s = (count_r == {CW{1'b0}}) && ack_ok_s;
`else
  assign byp_s = 1'b0;
`endif

  // A bypassed word that is consumed in the same cycle never enters the queue.
  assign enq_s = ack_ok_s && !(byp_s && deq);
  assign deq_s = deq && !redirect && (count_r != {CW{1'b0}});

  // Queue occupancy and pointer updates; redirect flushes everything.
  always_comb begin
    count_next_s = count_r;
    rd_next_s    = rd_r;
    wr_next_s    = wr_r;
    if (redirect) begin
      count_next_s = {CW{1'b0}};
      rd_next_s    = {PW{1'b0}};
      wr_next_s    = {PW{1'b0}};
    end else begin
      count_next_s = count_r + {{(CW-1){1'b0}}, enq_s} - {{(CW-1){1'b0}}, deq_s};
      rd_next_s    = rd_r + {{(PW-1){1'b0}}, deq_s};
      wr_next_s    = wr_r + {{(PW-1){1'b0}}, enq_s};
    end
  end

  // Fetch FSM next-state and fetch-PC logic.
  always_comb begin
    state_next_s = state_r;
    fpc_next_s   = fpc_r;
    hold_next_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          fpc_next_s = rpc_s;
        end else if (count_r < FULL_C) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (redirect) begin
          fpc_next_s = rpc_s;
          // Without ack the old request is still outstanding and must be drained.
          if (imem_ack) begin
            state_next_s = WAIT;
          end else begin
            state_next_s = DROP;
            hold_next_s  = fpc_r;
          end
        end else if (imem_ack) begin
          fpc_next_s   = fpc_r + 32'd4;
          state_next_s = (count_next_s < FULL_C) ? WAIT : IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_next_s = rpc_s;
        end else begin
          fpc_next_s = fpc_r;
        end
        if (imem_ack) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, fetch address, registered handshake outputs and queue storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      fpc_r   <= RESET_PC;
      hold_r  <= RESET_PC;
      addr_r  <= RESET_PC;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      count_r <= {CW{1'b0}};
      rd_r    <= {PW{1'b0}};
      wr_r    <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= 32'd0;
        pc_mem_r[i]   <= 32'd0;
      end
    end else begin
      state_r <= state_next_s;
      fpc_r   <= fpc_next_s;
      hold_r  <= hold_next_s;
      addr_r  <= (state_next_s == DROP) ? hold_next_s : fpc_next_s;
      req_r   <= (state_next_s != IDLE);
      valid_r <= (count_next_s != {CW{1'b0}});
      count_r <= count_next_s;
      rd_r    <= rd_next_s;
      wr_r    <= wr_next_s;
      if (enq_s) begin
        inst_mem_r[wr_r] <= imem_rdata;
        pc_mem_r[wr_r]   <= fpc_r;
      end else begin
        inst_mem_r[wr_r] <= inst_mem_r[wr_r];
        pc_mem_r[wr_r]   <= pc_mem_r[wr_r];
      end
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = addr_r;
  assign count      = count_r;
  assign inst_valid = valid_r | byp_s;
  assign inst       = byp_s ? imem_rdata : inst_mem_r[rd_r];
  assign inst_pc    = byp_s ? fpc_r      : pc_mem_r[rd_r];

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed handshake/redirect steps, then a randomized
// ack/deq run compared against a PC-queue reference model.
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .deq(deq), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .count(count)
  );

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] mq[$];
  logic [31:0] exp_fetch;
  int          consumed;
  bit          a, d, done;

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; deq = 1'b0;

    // 1. reset and first request
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    rst = 1'b0;
    tick;
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h3000);
    chk("c1_valid", 32'(inst_valid), 32'd0);

    // 2. back-to-back fill
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_addr", imem_addr, 32'h3000 + 32'(4 * i));
      imem_ack = 1'b1;
      imem_rdata = word_of(32'h3000 + 32'(4 * i));
      tick;
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    imem_ack = 1'b0;
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_pc", inst_pc, 32'h3000);
    chk("full_inst", inst, word_of(32'h3000));

    // 3. single dequeue from full
    deq = 1'b1;
    tick;
    deq = 1'b0;
    chk("deq_count", 32'(count), 32'd3);
    chk("deq_pc", inst_pc, 32'h3004);
    chk("deq_inst", inst, word_of(32'h3004));
    tick;
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h3010);

    // 4. redirect while waiting, late ack dropped
    redirect = 1'b1; redirect_pc = 32'h4002;
    tick;
    redirect = 1'b0;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'h3010);
    imem_ack = 1'b1; imem_rdata = 32'hbad0_bad0;
    tick;
    imem_ack = 1'b0;
    chk("dropped_count", 32'(count), 32'd0);
    chk("dropped_valid", 32'(inst_valid), 32'd0);
    chk("newtgt_addr", imem_addr, 32'h4000);
    imem_ack = 1'b1; imem_rdata = word_of(32'h4000);
    tick;
    imem_ack = 1'b0;
    chk("newtgt_count", 32'(count), 32'd1);
    chk("newtgt_pc", inst_pc, 32'h4000);
    chk("newtgt_next", imem_addr, 32'h4004);

    // 5. dequeue on empty, then redirect colliding with ack
    deq = 1'b1;
    tick;
    chk("drain_count", 32'(count), 32'd0);
    tick;
    deq = 1'b0;
    chk("empty_deq_count", 32'(count), 32'd0);
    chk("empty_deq_valid", 32'(inst_valid), 32'd0);
    chk("empty_deq_addr", imem_addr, 32'h4004);
    imem_ack = 1'b1; imem_rdata = word_of(32'h4004);
    tick;
    chk("pre_collide_count", 32'(count), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h5001; imem_rdata = 32'hdead_beef;
    tick;
    imem_ack = 1'b0; redirect = 1'b0;
    chk("collide_count", 32'(count), 32'd0);
    chk("collide_valid", 32'(inst_valid), 32'd0);
    chk("collide_req", 32'(imem_req), 32'd1);
    chk("collide_addr", imem_addr, 32'h5000);

    // reset while a request is outstanding
    rst = 1'b1;
    tick;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    rst = 1'b0;

    // 6. randomized ack/deq against the reference model
    exp_fetch = 32'h3000;
    consumed = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (consumed >= 20) begin
        done = 1'b1;
        break;
      end
      imem_ack = 1'b0; deq = 1'b0;
      #1;
      chk("rnd_count", 32'(count), 32'(mq.size()));
      chk("rnd_valid", 32'(inst_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
      if (mq.size() != 0) begin
        chk("rnd_pc", inst_pc, mq[0]);
        chk("rnd_inst", inst, word_of(mq[0]));
      end
      if (mq.size() == DEPTH) chk("rnd_full_req", 32'(imem_req), 32'd0);
      if (imem_req) chk("rnd_addr", imem_addr, exp_fetch);
      a = imem_req && ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 1) == 1);
      imem_ack = a; deq = d; imem_rdata = word_of(exp_fetch);
`ifdef IFQ_BYPASS_EN
      #1;
      if (a && mq.size() == 0) begin
        chk("byp_valid", 32'(inst_valid), 32'd1);
        chk("byp_pc", inst_pc, exp_fetch);
        chk("byp_inst", inst, word_of(exp_fetch));
      end
      if (a && d && mq.size() == 0) begin
        consumed++;
      end else begin
        if (d && mq.size() != 0) begin
          void'(mq.pop_front());
          consumed++;
        end
        if (a) mq.push_back(exp_fetch);
      end
`else
      if (d && mq.size() != 0) begin
        void'(mq.pop_front());
        consumed++;
      end
      if (a) mq.push_back(exp_fetch);
`endif
      if (a) exp_fetch = exp_fetch + 32'd4;
      tick;
    end
    imem_ack = 1'b0; deq = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL rnd_timeout observed=%0d expected=20 words consumed", consumed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
